// File: rtl/hazard_scoreboard_pkg.sv
// Shared CPU definitions for the hazard scoreboard.
// Holds the mul/div class encoding, the shadow-entry layout and small helpers.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10
  } md_class_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       rfwr;
    logic       isload;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_BUBBLE = '0;

  // The 2'b11 encoding has no meaning; it decodes to MD_NONE so it never starts the unit.
  function automatic md_class_e md_decode(input logic [1:0] raw);
    md_class_e cls;
    case (raw)
      2'b01:   cls = MD_MUL;
      2'b10:   cls = MD_DIV;
      default: cls = MD_NONE;
    endcase
    return cls;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_busy_fsm.sv
// HI/LO busy tracker for the multi-cycle multiply/divide unit.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | HI/LO results are valid; a mul/div may issue
// BUSY  | mul/div in flight; counter holds the remaining busy cycles - 1
module hilo_busy_fsm
  import hazard_scoreboard_pkg::*;
#(
  parameter int DIV_CYCLES = 36,
  parameter int MUL_CYCLES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic start_div,
  input  logic flush,
  output logic hilo_busy
);

  localparam int CNT_W = $clog2(max_int(DIV_CYCLES, MUL_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;

  // State, counter and registered busy flag; a flush aborts the unit outright.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hilo_busy <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hilo_busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_BUSY;
            cnt       <= start_div ? DIV_LOAD : MUL_LOAD;
            hilo_busy <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state     <= ST_IDLE;
            hilo_busy <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          hilo_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: shadows issued writers through EXE/MEM/WB and
// raises a stall when forwarding cannot deliver an operand in time.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int DIV_CYCLES = 36,
  parameter int MUL_CYCLES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       Pipe_Adv,
  input  logic       Flush,
  input  logic       ID_Valid,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_ReadRs,
  input  logic       ID_ReadRt,
  input  logic [4:0] ID_Dst,
  input  logic       ID_RFWr,
  input  logic       ID_IsLoad,
  input  logic [1:0] ID_MulDiv,
  input  logic       ID_HiLoRead,
  output logic       ID_Stall,
  output logic       ID_StallLoadUse,
  output logic       ID_StallHiLo,
  output logic       HiLo_Busy
);

  shadow_entry_t exe_q, mem_q, wb_q;
  shadow_entry_t id_entry;
  md_class_e     id_md;
  logic          issue_ok;
  logic          md_start;
  logic          exe_load_live;
  logic          rs_hit, rt_hit;

  assign id_md    = md_decode(ID_MulDiv);
  assign id_entry = '{valid: 1'b1, dst: ID_Dst, rfwr: ID_RFWr, isload: ID_IsLoad};

  // Issue qualification; the FSM only starts when the instruction actually moves into EXE.
  always_comb begin
    issue_ok = ID_Valid & ~ID_Stall & ~Flush;
    md_start = issue_ok & Pipe_Adv & (id_md != MD_NONE);
  end

  // Load-use: only a load still in EXE is too late for forwarding; $0 is never a hazard.
  always_comb begin
    exe_load_live   = exe_q.valid & exe_q.isload & exe_q.rfwr & (exe_q.dst != 5'd0);
    rs_hit          = ID_ReadRs & (ID_rs == exe_q.dst);
    rt_hit          = ID_ReadRt & (ID_rt == exe_q.dst);
    ID_StallLoadUse = ID_Valid & exe_load_live & (rs_hit | rt_hit);
  end

  // HI/LO readers and further mul/div both wait while the unit is busy.
  always_comb begin
    ID_StallHiLo = HiLo_Busy & ID_Valid & (ID_HiLoRead | (id_md != MD_NONE));
    ID_Stall     = ID_StallLoadUse | ID_StallHiLo;
  end

  // Shadow pipeline; flush kills the younger EXE/MEM entries but WB still commits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exe_q <= SHADOW_BUBBLE;
      mem_q <= SHADOW_BUBBLE;
      wb_q  <= SHADOW_BUBBLE;
    end else if (Flush) begin
      exe_q <= SHADOW_BUBBLE;
      mem_q <= SHADOW_BUBBLE;
    end else if (Pipe_Adv) begin
      wb_q  <= mem_q;
      mem_q <= exe_q;
      exe_q <= issue_ok ? id_entry : SHADOW_BUBBLE;
    end
  end

  hilo_busy_fsm #(
    .DIV_CYCLES(DIV_CYCLES),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_hilo_busy_fsm (
    .clk      (clk),
    .resetn   (resetn),
    .start    (md_start),
    .start_div(id_md == MD_DIV),
    .flush    (Flush),
    .hilo_busy(HiLo_Busy)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       resetn;
  logic       Pipe_Adv, Flush, ID_Valid;
  logic [4:0] ID_rs, ID_rt, ID_Dst;
  logic       ID_ReadRs, ID_ReadRt, ID_RFWr, ID_IsLoad, ID_HiLoRead;
  logic [1:0] ID_MulDiv;
  logic       ID_Stall, ID_StallLoadUse, ID_StallHiLo, HiLo_Busy;

  int checks = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DIV_CYCLES(36), .MUL_CYCLES(2)) dut (
    .clk(clk), .resetn(resetn), .Pipe_Adv(Pipe_Adv), .Flush(Flush),
    .ID_Valid(ID_Valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_ReadRs(ID_ReadRs), .ID_ReadRt(ID_ReadRt), .ID_Dst(ID_Dst),
    .ID_RFWr(ID_RFWr), .ID_IsLoad(ID_IsLoad), .ID_MulDiv(ID_MulDiv),
    .ID_HiLoRead(ID_HiLoRead), .ID_Stall(ID_Stall),
    .ID_StallLoadUse(ID_StallLoadUse), .ID_StallHiLo(ID_StallHiLo),
    .HiLo_Busy(HiLo_Busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rrs, input logic rrt, input logic [4:0] dst,
                        input logic rfwr, input logic ld, input logic [1:0] md,
                        input logic hr);
    ID_Valid = v; ID_rs = rs; ID_rt = rt; ID_ReadRs = rrs; ID_ReadRt = rrt;
    ID_Dst = dst; ID_RFWr = rfwr; ID_IsLoad = ld; ID_MulDiv = md; ID_HiLoRead = hr;
  endtask

  task automatic set_lw(input logic [4:0] dst);
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, dst, 1'b1, 1'b1, 2'b00, 1'b0);
  endtask

  task automatic set_mflo();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 2'b00, 1'b1);
  endtask

  task automatic set_md(input logic [1:0] md);
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, md, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; Pipe_Adv = 1'b1; Flush = 1'b0;
    set_mflo();
    repeat (2) step();
    check("rst_stall", int'(ID_Stall), 0);
    check("rst_loaduse", int'(ID_StallLoadUse), 0);
    check("rst_hilo", int'(ID_StallHiLo), 0);
    check("rst_busy", int'(HiLo_Busy), 0);
    resetn = 1'b1;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    step();

    // lw $3 then add reading $3: one bubble, then the add issues
    set_lw(5'd3); #1;
    check("lw3_issue", int'(ID_Stall), 0);
    step();
    set_id(1'b1, 5'd3, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 2'b00, 1'b0); #1;
    check("lu_stall", int'(ID_Stall), 1);
    check("lu_cause", int'(ID_StallLoadUse), 1);
    check("lu_not_hilo", int'(ID_StallHiLo), 0);
    step(); #1;
    check("lu_released", int'(ID_Stall), 0);
    step();
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 2'b00, 1'b0); #1;
    check("add_in_exe", int'(ID_Stall), 0);
    step();

    // load to $0 never stalls
    set_lw(5'd0); step();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 2'b00, 1'b0); #1;
    check("lu_dst0", int'(ID_Stall), 0);
    step();

    // rt path, read-enable and ID_Valid gating
    set_lw(5'd7); step();
    set_id(1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 2'b00, 1'b0); #1;
    check("lu_rt_noread", int'(ID_Stall), 0);
    ID_ReadRt = 1'b1; #1;
    check("lu_rt_read", int'(ID_StallLoadUse), 1);
    ID_Valid = 1'b0; #1;
    check("lu_invalid", int'(ID_Stall), 0);
    step();

    // load two apart is covered by forwarding
    set_lw(5'd5); step();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0); #1;
    check("nop_after_lw", int'(ID_Stall), 0);
    step();
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 2'b00, 1'b0); #1;
    check("lw_two_apart", int'(ID_Stall), 0);
    step();

    // pipeline hold keeps the load in EXE
    set_lw(5'd6); step();
    Pipe_Adv = 1'b0;
    set_id(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1; check($sformatf("hold_stall_%0d", i), int'(ID_StallLoadUse), 1);
      step();
    end
    Pipe_Adv = 1'b1; #1;
    check("hold_release_stall", int'(ID_Stall), 1);
    step(); #1;
    check("hold_after_bubble", int'(ID_Stall), 0);
    step();

    // div then mflo: 36 stall cycles
    set_md(2'b10); #1;
    check("div_issue_nostall", int'(ID_Stall), 0);
    step();
    set_mflo(); #1;
    check("div_busy", int'(HiLo_Busy), 1);
    n = 0;
    while (ID_StallHiLo && n < 100) begin n++; step(); #1; end
    check("div_stall_cycles", n, 36);
    check("div_idle", int'(HiLo_Busy), 0);
    step();

    // mult then mflo: 2 stall cycles
    set_md(2'b01); step();
    set_mflo(); #1;
    n = 0;
    while (ID_StallHiLo && n < 100) begin n++; step(); #1; end
    check("mul_stall_cycles", n, 2);
    step();

    // illegal class 11 does not start the unit
    set_md(2'b11); step(); #1;
    check("md11_no_busy", int'(HiLo_Busy), 0);
    step();

    // back-to-back mult then div, then flush at BUSY cycle 10
    set_md(2'b01); step();
    set_md(2'b10); #1;
    check("b2b_div_stall", int'(ID_StallHiLo), 1);
    n = 0;
    while (ID_StallHiLo && n < 100) begin n++; step(); #1; end
    check("b2b_div_wait", n, 2);
    step(); #1;
    check("b2b_reload_busy", int'(HiLo_Busy), 1);
    set_mflo();
    repeat (9) step();
    Flush = 1'b1; #1;
    check("flush_pre_busy", int'(HiLo_Busy), 1);
    step();
    Flush = 1'b0; #1;
    check("flush_busy_clear", int'(HiLo_Busy), 0);
    check("flush_mflo_free", int'(ID_StallHiLo), 0);

    // flush clears EXE/MEM, keeps WB, and beats a same-cycle issue
    set_lw(5'd9);  step();
    set_lw(5'd10); step();
    set_lw(5'd11); step();
    Flush = 1'b1; set_lw(5'd12); step();
    Flush = 1'b0; #1;
    check("flush_exe_invalid", int'(dut.exe_q.valid), 0);
    check("flush_mem_invalid", int'(dut.mem_q.valid), 0);
    check("flush_wb_valid", int'(dut.wb_q.valid), 1);
    check("flush_wb_dst", int'(dut.wb_q.dst), 9);
    set_id(1'b1, 5'd12, 5'd11, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 2'b00, 1'b0); #1;
    check("flush_no_loaduse", int'(ID_Stall), 0);
    Flush = 1'b1; set_md(2'b10); step();
    Flush = 1'b0; #1;
    check("flush_beats_div", int'(HiLo_Busy), 0);

    // asynchronous reset in the middle of a divide
    set_md(2'b10); step();
    set_mflo();
    repeat (4) step();
    #1;
    check("rst_mid_pre_busy", int'(HiLo_Busy), 1);
    resetn = 1'b0; #1;
    check("rst_mid_busy", int'(HiLo_Busy), 0);
    check("rst_mid_stall", int'(ID_Stall), 0);
    check("rst_mid_hilo", int'(ID_StallHiLo), 0);
    step();
    resetn = 1'b1; #1;
    check("rst_exe_empty", int'(dut.exe_q.valid), 0);
    check("rst_wb_empty", int'(dut.wb_q.valid), 0);
    check("rst_mflo_free", int'(ID_Stall), 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
